// File: rtl/palette_ram_arbiter_pkg.sv
// Shared types for the palette RAM arbiter: FSM state encoding, default
// widths and the layout of one buffered CPU write.
package palette_arb_pkg;

  localparam int AW_DEF          = 13;
  localparam int DW_DEF          = 16;
  localparam int WFIFO_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_PEND  = 2'd1,
    RD_DATA  = 2'd2,
    ACK_WAIT = 2'd3
  } arb_state_e;

  typedef struct packed {
    logic [AW_DEF-1:0] addr;
    logic [1:0]        be;
    logic [DW_DEF-1:0] data;
  } wfifo_entry_t;

endpackage

// File: rtl/palette_ram_arbiter_if.sv
// Bundle of the video, CPU and RAM-side signals of the palette arbiter.
interface palette_ram_arbiter_if #(
  parameter int AW = 13,
  parameter int DW = 16
);

  // CPU handshake: cpu_req is a level held (with cpu_we/addr/be/din stable)
  // until cpu_ack has been seen high; cpu_ack is a single-cycle pulse and
  // cpu_dout is only meaningful while cpu_ack=1. A new request may start
  // once cpu_req has been low for at least one rising edge.
  logic          ce_pixel;
  logic [AW-1:0] vid_addr;
  logic [DW-1:0] vid_data;

  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [1:0]    cpu_be;
  logic [DW-1:0] cpu_din;
  logic [DW-1:0] cpu_dout;
  logic          cpu_ack;

  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic          ram_we_l;
  logic          ram_we_h;

  logic          wfifo_full;

  modport slave (
    input  ce_pixel, vid_addr,
    input  cpu_req, cpu_we, cpu_addr, cpu_be, cpu_din,
    input  ram_rdata,
    output vid_data, cpu_dout, cpu_ack,
    output ram_addr, ram_wdata, ram_we_l, ram_we_h,
    output wfifo_full
  );

  modport master (
    output ce_pixel, vid_addr,
    output cpu_req, cpu_we, cpu_addr, cpu_be, cpu_din,
    output ram_rdata,
    input  vid_data, cpu_dout, cpu_ack,
    input  ram_addr, ram_wdata, ram_we_l, ram_we_h,
    input  wfifo_full
  );

endinterface

// File: rtl/palette_ram_arbiter_wr_fifo.sv
// CPU write buffer: power-of-two circular FIFO with a show-ahead head entry.
module palette_wr_fifo
  import palette_arb_pkg::*;
#(
  parameter int  DEPTH   = WFIFO_DEPTH_DEF,
  parameter type entry_t = wfifo_entry_t
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  entry_t                 din_i,
  input  logic                   pop_i,
  output entry_t                 dout_o,
  output logic                   empty_o,
  output logic                   full_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PW = $clog2(DEPTH);

  entry_t        mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          do_push;
  logic          do_pop;

  // Guards make an overflowing push or an underflowing pop a no-op.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/palette_ram_arbiter.sv
// Shares one palette RAM between the pixel pipeline (ce_pixel slots) and a
// CPU port with a buffered write path and read-after-write ordered reads.
module palette_ram_arbiter
  import palette_arb_pkg::*;
#(
  parameter int AW          = AW_DEF,
  parameter int DW          = DW_DEF,
  parameter int WFIFO_DEPTH = WFIFO_DEPTH_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  palette_ram_arbiter_if.slave         bus,
  output arb_state_e                   state_dbg_o,
  output logic [$clog2(WFIFO_DEPTH):0] wfifo_count_dbg_o
);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [1:0]    be;
    logic [DW-1:0] data;
  } entry_t;

  arb_state_e    state_q, state_d;
  logic          ack_q, ack_d;
  logic [DW-1:0] cpu_dout_q, cpu_dout_d;
  logic [DW-1:0] vid_data_q, vid_data_d;
  logic          vid_pend_q, vid_pend_d;

  entry_t        push_entry;
  entry_t        fifo_head;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_empty;
  logic          fifo_full;
  logic          rd_issue;

  logic [AW-1:0] ram_addr_c;
  logic [DW-1:0] ram_wdata_c;
  logic          ram_we_l_c;
  logic          ram_we_h_c;

  assign push_entry = {bus.cpu_addr, bus.cpu_be, bus.cpu_din};

  palette_wr_fifo #(
    .DEPTH   (WFIFO_DEPTH),
    .entry_t (entry_t)
  ) u_wr_fifo (
    .clk     (clk),
    .rst     (reset),
    .push_i  (fifo_push),
    .din_i   (push_entry),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (wfifo_count_dbg_o)
  );

  // Slot mux: video owns the RAM when ce_pixel=1; otherwise buffered writes
  // drain first, so a pending read can only issue once the FIFO is empty.
  always_comb begin
    ram_addr_c  = bus.vid_addr;
    ram_wdata_c = fifo_head.data;
    ram_we_l_c  = 1'b0;
    ram_we_h_c  = 1'b0;
    fifo_pop    = 1'b0;
    rd_issue    = 1'b0;
    if (!bus.ce_pixel) begin
      if (!fifo_empty) begin
        fifo_pop   = 1'b1;
        ram_addr_c = fifo_head.addr;
        ram_we_l_c = fifo_head.be[0];
        ram_we_h_c = fifo_head.be[1];
      end else if (state_q == RD_PEND) begin
        ram_addr_c = bus.cpu_addr;
        rd_issue   = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ack_d      = 1'b0;
    fifo_push  = 1'b0;
    cpu_dout_d = cpu_dout_q;
    vid_pend_d = bus.ce_pixel;
    vid_data_d = vid_pend_q ? bus.ram_rdata : vid_data_q;
    case (state_q)
      IDLE: begin
        if (bus.cpu_req) begin
          if (bus.cpu_we) begin
            // A write with no byte enables is acknowledged but never queued.
            if (!fifo_full) begin
              fifo_push = |bus.cpu_be;
              ack_d     = 1'b1;
              state_d   = ACK_WAIT;
            end
          end else begin
            state_d = RD_PEND;
          end
        end
      end
      RD_PEND: begin
        if (rd_issue) state_d = RD_DATA;
      end
      RD_DATA: begin
        cpu_dout_d = bus.ram_rdata;
        ack_d      = 1'b1;
        state_d    = ACK_WAIT;
      end
      ACK_WAIT: begin
        if (!bus.cpu_req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      ack_q      <= 1'b0;
      cpu_dout_q <= '0;
      vid_data_q <= '0;
      vid_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ack_q      <= ack_d;
      cpu_dout_q <= cpu_dout_d;
      vid_data_q <= vid_data_d;
      vid_pend_q <= vid_pend_d;
    end
  end

  assign bus.ram_addr   = ram_addr_c;
  assign bus.ram_wdata  = ram_wdata_c;
  assign bus.ram_we_l   = ram_we_l_c;
  assign bus.ram_we_h   = ram_we_h_c;
  assign bus.cpu_ack    = ack_q;
  assign bus.cpu_dout   = cpu_dout_q;
  assign bus.vid_data   = vid_data_q;
  assign bus.wfifo_full = fifo_full;
  assign state_dbg_o    = state_q;

endmodule

// File: tb/tb_palette_ram_arbiter.sv
// Bench for palette_ram_arbiter: behavioural RAM, shadow memory and a queue of
// expected RAM writes checked as the arbiter performs them.
module tb_palette_ram_arbiter;
  import palette_arb_pkg::*;

  localparam int AW    = 13;
  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int EW    = AW + 2 + DW;
  localparam int NW    = 1 << AW;

  logic       clk;
  logic       reset;
  arb_state_e state_dbg;
  logic [2:0] wfifo_count_dbg;

  palette_ram_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  palette_ram_arbiter #(.AW(AW), .DW(DW), .WFIFO_DEPTH(DEPTH)) dut (
    .clk               (clk),
    .reset             (reset),
    .bus               (bus),
    .state_dbg_o       (state_dbg),
    .wfifo_count_dbg_o (wfifo_count_dbg)
  );

  int            n_total;
  int            n_bad;
  int            ack_cnt;
  int            ram_wr_cnt;
  logic          rand_ce;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_e;
  logic [DW-1:0] ram_mem [NW];
  logic [DW-1:0] shadow  [NW];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- RAM model: 1-cycle synchronous read ----------------
  always @(posedge clk) begin
    if (bus.ram_we_l) ram_mem[bus.ram_addr][DW/2-1:0]  <= bus.ram_wdata[DW/2-1:0];
    if (bus.ram_we_h) ram_mem[bus.ram_addr][DW-1:DW/2] <= bus.ram_wdata[DW-1:DW/2];
    bus.ram_rdata <= ram_mem[bus.ram_addr];
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard: RAM writes ----------------
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.cpu_ack) ack_cnt++;
      if (bus.ram_we_l || bus.ram_we_h) begin
        ram_wr_cnt++;
        if (exp_q.size() == 0) begin
          check_val("ram_wr_unexpected", 32'(exp_q.size()), 32'd1);
        end else begin
          mon_e = exp_q.pop_front();
          check_val("ram_wr", 32'({bus.ram_addr, bus.ram_we_h, bus.ram_we_l, bus.ram_wdata}), 32'(mon_e));
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_ce) bus.ce_pixel = ($urandom_range(0, 3) == 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cpu_write(input logic [AW-1:0] a, input logic [1:0] be,
                           input logic [DW-1:0] d, output int lat);
    int cyc;
    @(posedge clk); #1;
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b1;
    bus.cpu_addr = a;
    bus.cpu_be   = be;
    bus.cpu_din  = d;
    if (be != 2'b00) exp_q.push_back({a, be[1], be[0], d});
    if (be[0]) shadow[a][DW/2-1:0]  = d[DW/2-1:0];
    if (be[1]) shadow[a][DW-1:DW/2] = d[DW-1:DW/2];
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!bus.cpu_ack && cyc < 200);
    lat = bus.cpu_ack ? cyc - 1 : -1;
    @(posedge clk); #1;
    bus.cpu_req = 1'b0;
    bus.cpu_we  = 1'b0;
  endtask

  task automatic cpu_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output int lat);
    int cyc;
    @(posedge clk); #1;
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = a;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!bus.cpu_ack && cyc < 200);
    lat = bus.cpu_ack ? cyc - 1 : -1;
    d   = bus.cpu_dout;
    @(posedge clk); #1;
    bus.cpu_req = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int            lat;
    int            lat5;
    int            lat_base;
    int            lat_def;
    int            ack_b;
    int            wr_b;
    logic [DW-1:0] rd;
    logic [DW-1:0] exp_rd;
    logic [DW-1:0] old0;
    logic [DW-1:0] old1;
    logic [AW-1:0] ra;

    n_total = 0; n_bad = 0; ack_cnt = 0; ram_wr_cnt = 0; rand_ce = 1'b0;
    bus.ce_pixel = 1'b0; bus.vid_addr = '0;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0;
    bus.cpu_be = 2'b00; bus.cpu_din = '0;
    for (int i = 0; i < NW; i++) begin
      ram_mem[i] = DW'(i * 37) ^ 16'h5A3C;
      shadow[i]  = DW'(i * 37) ^ 16'h5A3C;
    end
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_ack",      bus.cpu_ack, 0);
    check_val("rst_dout",     bus.cpu_dout, 0);
    check_val("rst_vid_data", bus.vid_data, 0);
    check_val("rst_we",       {bus.ram_we_h, bus.ram_we_l}, 0);
    check_val("rst_full",     bus.wfifo_full, 0);
    check_val("rst_state",    state_dbg, IDLE);
    @(posedge clk); #1;
    reset = 1'b0;

    // Three back-to-back writes in CPU slots
    for (int i = 0; i < 3; i++) begin
      cpu_write(AW'(13'h010 + i), 2'b11, DW'(16'hA000 + i * 16'h0111), lat);
      check_val("t1_wr_lat", lat, 1);
    end
    repeat (3) @(negedge clk);
    check_val("t1_drained", exp_q.size(), 0);
    check_val("t1_count", wfifo_count_dbg, 0);

    // Video hogs the RAM: buffer fills, fifth write stalls
    @(posedge clk); #1;
    bus.ce_pixel = 1'b1;
    bus.vid_addr = 13'h020;
    for (int i = 0; i < 4; i++) begin
      cpu_write(AW'(13'h030 + i), 2'b11, DW'(16'hC000 + i), lat);
      check_val("t2_wr_lat", lat, 1);
    end
    @(negedge clk);
    check_val("t2_full", bus.wfifo_full, 1);
    check_val("t2_count", wfifo_count_dbg, 4);
    ack_b = ack_cnt;
    wr_b  = ram_wr_cnt;
    fork
      cpu_write(13'h034, 2'b11, 16'hBEEF, lat5);
      begin
        repeat (8) @(negedge clk);
        check_val("t2_stall_noack", ack_cnt - ack_b, 0);
        check_val("t2_no_wr_video", ram_wr_cnt - wr_b, 0);
        @(posedge clk); #1;
        bus.ce_pixel = 1'b0;
      end
    join
    check_val("t2_wr5_lat", lat5, 10);
    repeat (4) @(negedge clk);
    check_val("t2_drained", exp_q.size(), 0);
    check_val("t2_not_full", bus.wfifo_full, 0);

    // Byte write then read-back: read must wait for the buffered write
    old0 = shadow[13'h0A0];
    @(posedge clk); #1;
    bus.ce_pixel = 1'b1;
    cpu_write(13'h0A0, 2'b01, 16'h1234, lat);
    check_val("t3_wr_lat", lat, 1);
    ack_b = ack_cnt;
    fork
      cpu_read(13'h0A0, rd, lat);
      begin
        repeat (5) @(negedge clk);
        check_val("t3_rd_waits", ack_cnt - ack_b, 0);
        @(posedge clk); #1;
        bus.ce_pixel = 1'b0;
      end
    join
    check_val("t3_rd_ack", lat > 0, 1);
    check_val("t3_rd_data", rd, {old0[15:8], 8'h34});

    // Video slot landing on the read-issue cycle defers the read by one cycle
    cpu_read(13'h0B0, rd, lat_base);
    check_val("t4_base_data", rd, shadow[13'h0B0]);
    fork
      cpu_read(13'h0C0, rd, lat_def);
      begin
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.ce_pixel = 1'b1;
        bus.vid_addr = 13'h155;
        @(negedge clk);
        check_val("t4_vid_addr", bus.ram_addr, 13'h155);
        check_val("t4_vid_we", {bus.ram_we_h, bus.ram_we_l}, 0);
        @(posedge clk); #1;
        bus.ce_pixel = 1'b0;
      end
    join
    check_val("t4_defer", lat_def, lat_base + 1);
    check_val("t4_def_data", rd, shadow[13'h0C0]);
    repeat (2) @(negedge clk);
    check_val("t4_vid_data", bus.vid_data, shadow[13'h155]);

    // Reset with two writes buffered and a read pending
    old0 = shadow[13'h1E0];
    old1 = shadow[13'h1E1];
    @(posedge clk); #1;
    bus.ce_pixel = 1'b1;
    cpu_write(13'h1E0, 2'b11, 16'h1111, lat);
    check_val("t5_wr_lat0", lat, 1);
    cpu_write(13'h1E1, 2'b11, 16'h2222, lat);
    check_val("t5_wr_lat1", lat, 1);
    @(posedge clk); #1;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 13'h1E0;
    repeat (3) @(negedge clk);
    check_val("t5_rd_pend", state_dbg, RD_PEND);
    check_val("t5_count", wfifo_count_dbg, 2);
    ack_b = ack_cnt;
    @(posedge clk); #1;
    reset = 1'b1;
    bus.cpu_req = 1'b0;
    bus.ce_pixel = 1'b0;
    exp_q.delete();
    shadow[13'h1E0] = old0;
    shadow[13'h1E1] = old1;
    @(negedge clk);
    check_val("t5_rst_count", wfifo_count_dbg, 0);
    check_val("t5_rst_state", state_dbg, IDLE);
    check_val("t5_rst_dout", bus.cpu_dout, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    wr_b = ram_wr_cnt;
    repeat (8) @(negedge clk);
    check_val("t5_no_ack", ack_cnt - ack_b, 0);
    check_val("t5_no_wr", ram_wr_cnt - wr_b, 0);
    cpu_read(13'h1E0, rd, lat);
    check_val("t5_old_data", rd, old0);

    // Write with no byte enables: ack only
    wr_b = ram_wr_cnt;
    cpu_write(13'h0D0, 2'b00, 16'hFFFF, lat);
    check_val("t6_wr_lat", lat, 1);
    repeat (3) @(negedge clk);
    check_val("t6_no_we", ram_wr_cnt - wr_b, 0);
    cpu_read(13'h0D0, rd, lat);
    check_val("t6_unchanged", rd, shadow[13'h0D0]);

    // Random traffic with random video slots
    rand_ce = 1'b1;
    for (int i = 0; i < 24; i++) begin
      ra = AW'(13'h100 + $urandom_range(0, 7));
      if ($urandom_range(0, 2) == 0) begin
        exp_rd = shadow[ra];
        cpu_read(ra, rd, lat);
        check_val("rnd_rd", rd, exp_rd);
      end else begin
        cpu_write(ra, 2'($urandom_range(0, 3)), DW'($urandom_range(0, 65535)), lat);
        check_val("rnd_wr_ack", lat > 0, 1);
      end
    end
    rand_ce = 1'b0;
    @(posedge clk); #1;
    bus.ce_pixel = 1'b0;
    repeat (8) @(negedge clk);
    check_val("rnd_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
